// File: rtl/spi_ram_ctrl_if.sv
// Word-stream link between the SPI slave and the RAM command decoder.
// The SPI slave side is the master here: it presents command words and collects read data.
interface spi_ram_ctrl_if;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       addr_err;

    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid,
        input  addr_err
    );

    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid,
        output addr_err
    );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Single-port RAM with a 2-bit command decoder fed by the SPI slave word stream.
// Commands execute once per rising edge of rx_valid; read data is held on dout/tx_valid.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter bit AUTO_INC  = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_ram_ctrl_if.slave bus
);
    localparam int                   MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_SIZE:0]   DEPTH_W   = (ADDR_SIZE + 1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    logic [7:0]           mem [MEM_DEPTH];

    logic                 rx_valid_q, rx_valid_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]           dout_q, dout_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 addr_err_q, addr_err_d;

    cmd_e                 cmd;
    logic [ADDR_SIZE-1:0] payload;
    logic                 accept;
    logic                 wr_in_range;
    logic                 rd_in_range;
    logic [MEM_AW-1:0]    wr_idx;
    logic [MEM_AW-1:0]    rd_idx;
    logic                 mem_we;

    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_SIZE'(1);
    endfunction

    assign cmd         = cmd_e'(bus.din[9:8]);
    assign payload     = ADDR_SIZE'(bus.din[7:0]);
    assign accept      = bus.rx_valid & ~rx_valid_q;
    assign wr_in_range = ({1'b0, wr_addr_q} < DEPTH_W);
    assign rd_in_range = ({1'b0, rd_addr_q} < DEPTH_W);
    assign wr_idx      = wr_addr_q[MEM_AW-1:0];
    assign rd_idx      = rd_addr_q[MEM_AW-1:0];

    always_comb begin
        rx_valid_d = bus.rx_valid;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        dout_d     = dout_q;
        tx_valid_d = tx_valid_q;
        addr_err_d = 1'b0;
        mem_we     = 1'b0;

        if (accept) begin
            // Any accepted command retires the previous read; RD_DATA re-asserts below.
            tx_valid_d = 1'b0;
            case (cmd)
                CMD_WR_ADDR: wr_addr_d = payload;
                CMD_WR_DATA: begin
                    if (wr_in_range) begin
                        mem_we = 1'b1;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                    if (AUTO_INC) begin
                        wr_addr_d = next_addr(wr_addr_q);
                    end
                end
                CMD_RD_ADDR: rd_addr_d = payload;
                CMD_RD_DATA: begin
                    tx_valid_d = 1'b1;
                    if (rd_in_range) begin
                        dout_d = mem[rd_idx];
                    end else begin
                        dout_d     = 8'h00;
                        addr_err_d = 1'b1;
                    end
                    if (AUTO_INC) begin
                        rd_addr_d = next_addr(rd_addr_q);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            dout_q     <= 8'h00;
            tx_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx] <= bus.din[7:0];
        end
    end

    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.addr_err = addr_err_q;
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench: three parameterisations share one command stream, each with its own model.
// Driver pushes expected responses; a negedge monitor pops and compares every cycle.
module tb_spi_ram_ctrl;
    localparam int NDUT = 3;

    typedef struct packed {
        logic       tx;
        logic [7:0] dout;
        logic       known;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = 10'h000;
    logic       rx_valid = 1'b0;

    int checks = 0;
    int failures = 0;
    int ntxn = 0;

    always #5 clk = ~clk;

    spi_ram_ctrl_if bus0 ();
    spi_ram_ctrl_if bus1 ();
    spi_ram_ctrl_if bus2 ();

    assign bus0.din = din;
    assign bus0.rx_valid = rx_valid;
    assign bus1.din = din;
    assign bus1.rx_valid = rx_valid;
    assign bus2.din = din;
    assign bus2.rx_valid = rx_valid;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    spi_ram_ctrl #(.MEM_DEPTH(128), .ADDR_SIZE(8), .AUTO_INC(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    logic       obs_tx   [NDUT];
    logic [7:0] obs_dout [NDUT];
    logic       obs_err  [NDUT];

    assign obs_tx[0] = bus0.tx_valid;
    assign obs_tx[1] = bus1.tx_valid;
    assign obs_tx[2] = bus2.tx_valid;
    assign obs_dout[0] = bus0.dout;
    assign obs_dout[1] = bus1.dout;
    assign obs_dout[2] = bus2.dout;
    assign obs_err[0] = bus0.addr_err;
    assign obs_err[1] = bus1.addr_err;
    assign obs_err[2] = bus2.addr_err;

    // Reference model state, one slice per DUT.
    logic [7:0] m_mem   [NDUT][256];
    bit         m_val   [NDUT][256];
    int         m_wr    [NDUT];
    int         m_rd    [NDUT];
    logic       m_tx    [NDUT];
    logic [7:0] m_dout  [NDUT];
    bit         m_known [NDUT];
    exp_t       exp_q   [NDUT][$];

    function automatic int depth_of(input int k);
        return (k == 1) ? 128 : 256;
    endfunction

    function automatic bit ainc_of(input int k);
        return (k != 2);
    endfunction

    function automatic int bump(input int k, input int a);
        return (a == depth_of(k) - 1) ? 0 : (a + 1) % 256;
    endfunction

    function automatic void chk(input int k, input string name, input logic [7:0] act,
                                input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL dut%0d %s: got 0x%02h expected 0x%02h at t=%0t", k, name, act, expv, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_wr[k] = 0;
            m_rd[k] = 0;
            m_tx[k] = 1'b0;
            m_dout[k] = 8'h00;
            m_known[k] = 1'b1;
        end
    endfunction

    function automatic void model_cmd(input logic [1:0] cmd, input logic [7:0] p);
        for (int k = 0; k < NDUT; k++) begin
            exp_t e;
            e.err = 1'b0;
            case (cmd)
                2'd0: m_wr[k] = int'(p);
                2'd1: begin
                    if (m_wr[k] < depth_of(k)) begin
                        m_mem[k][m_wr[k]] = p;
                        m_val[k][m_wr[k]] = 1'b1;
                    end else begin
                        e.err = 1'b1;
                    end
                    if (ainc_of(k)) m_wr[k] = bump(k, m_wr[k]);
                end
                2'd2: m_rd[k] = int'(p);
                default: begin
                    if (m_rd[k] < depth_of(k)) begin
                        m_dout[k] = m_mem[k][m_rd[k]];
                        m_known[k] = m_val[k][m_rd[k]];
                    end else begin
                        m_dout[k] = 8'h00;
                        m_known[k] = 1'b1;
                        e.err = 1'b1;
                    end
                    if (ainc_of(k)) m_rd[k] = bump(k, m_rd[k]);
                end
            endcase
            m_tx[k] = (cmd == 2'd3);
            e.tx = m_tx[k];
            e.dout = m_dout[k];
            e.known = m_known[k];
            exp_q[k].push_back(e);
        end
    endfunction

    task automatic send(input logic [1:0] cmd, input logic [7:0] p, input int hold);
        @(negedge clk);
        din = {cmd, p};
        rx_valid = 1'b1;
        model_cmd(cmd, p);
        $display("txn %0d: cmd=%0d payload=0x%02h hold=%0d", ntxn, cmd, p, hold);
        ntxn++;
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Monitor: tracks rx_valid rising edges from the bench side of the link.
    logic rxv_prev = 1'b0;
    logic due = 1'b0;
    logic       cur_tx    [NDUT];
    logic [7:0] cur_dout  [NDUT];
    bit         cur_known [NDUT];

    always @(posedge clk) begin
        if (!rst_n) begin
            rxv_prev <= 1'b0;
            due <= 1'b0;
        end else begin
            due <= rx_valid && !rxv_prev;
            rxv_prev <= rx_valid;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NDUT; k++) begin
                cur_tx[k] = 1'b0;
                cur_dout[k] = 8'h00;
                cur_known[k] = 1'b1;
            end
        end else begin
            for (int k = 0; k < NDUT; k++) begin
                logic exp_err;
                exp_t e;
                exp_err = 1'b0;
                if (due) begin
                    if (exp_q[k].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL dut%0d scoreboard_empty: response seen with no expectation at t=%0t", k, $time);
                    end else begin
                        e = exp_q[k].pop_front();
                        cur_tx[k] = e.tx;
                        cur_dout[k] = e.dout;
                        cur_known[k] = e.known;
                        exp_err = e.err;
                    end
                end
                chk(k, "addr_err", {7'b0, obs_err[k]}, {7'b0, exp_err});
                chk(k, "tx_valid", {7'b0, obs_tx[k]}, {7'b0, cur_tx[k]});
                if (cur_tx[k] && cur_known[k]) begin
                    chk(k, "dout", obs_dout[k], cur_dout[k]);
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk(k, "reset_tx_valid", {7'b0, obs_tx[k]}, 8'h00);
            chk(k, "reset_dout", obs_dout[k], 8'h00);
            chk(k, "reset_addr_err", {7'b0, obs_err[k]}, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write then read back.
        send(2'd0, 8'h12, 1);
        send(2'd1, 8'hA5, 1);
        send(2'd2, 8'h12, 1);
        send(2'd3, 8'h00, 1);

        // Held rx_valid must execute the write exactly once.
        send(2'd0, 8'h40, 1);
        send(2'd1, 8'h5A, 20);
        send(2'd1, 8'h5B, 1);
        send(2'd2, 8'h40, 1);
        send(2'd3, 8'h00, 3);
        send(2'd2, 8'h41, 1);
        send(2'd3, 8'h00, 1);

        // Address wrap at the top of memory.
        send(2'd0, 8'hFF, 1);
        send(2'd1, 8'h11, 1);
        send(2'd1, 8'h22, 1);
        send(2'd1, 8'h33, 1);
        send(2'd2, 8'hFF, 1);
        send(2'd3, 8'h00, 1);
        send(2'd3, 8'h00, 1);
        send(2'd3, 8'h00, 1);

        // Out-of-range write and read on the shallow instance.
        send(2'd0, 8'h90, 1);
        send(2'd1, 8'h33, 1);
        send(2'd2, 8'h90, 1);
        send(2'd3, 8'h00, 1);
        send(2'd0, 8'h7F, 1);
        send(2'd1, 8'h44, 1);
        send(2'd1, 8'h55, 1);

        // tx_valid cleared by a following command; back-to-back reads keep it high.
        send(2'd2, 8'h12, 1);
        send(2'd3, 8'h00, 2);
        send(2'd0, 8'h00, 1);
        send(2'd2, 8'h12, 1);
        send(2'd3, 8'h00, 1);
        send(2'd3, 8'h00, 1);

        for (int i = 0; i < 300; i++) begin
            logic [1:0] c;
            logic [7:0] p;
            int h;
            c = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: p = 8'($urandom_range(0, 15));
                1: p = 8'($urandom_range(120, 135));
                default: p = 8'($urandom);
            endcase
            h = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 12)) : int'($urandom_range(1, 2));
            send(c, p, h);
        end

        // Asynchronous reset while tx_valid is high; rx_valid held through release.
        send(2'd2, 8'h12, 1);
        send(2'd3, 8'h00, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk(k, "async_rst_tx_valid", {7'b0, obs_tx[k]}, 8'h00);
            chk(k, "async_rst_dout", obs_dout[k], 8'h00);
            chk(k, "async_rst_addr_err", {7'b0, obs_err[k]}, 8'h00);
        end
        model_reset();
        repeat (2) @(negedge clk);
        din = {2'b11, 8'h00};
        rx_valid = 1'b1;
        model_cmd(2'b11, 8'h00);
        $display("txn %0d: cmd=3 payload=0x00 held across reset release", ntxn);
        ntxn++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;

        send(2'd2, 8'h12, 1);
        send(2'd3, 8'h00, 1);
        send(2'd2, 8'h05, 1);
        send(2'd3, 8'h00, 1);
        send(2'd3, 8'h00, 1);

        repeat (4) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk(k, "scoreboard_drained", 8'(exp_q[k].size()), 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
